// File: rtl/acc_bank_stack.sv
// Bank of NUM_ACC accumulators with Z/C/V flags and a save/restore stack.
// Optional macro ACC_SATURATE_EN: signed saturation of the accumulate (sel_src=11) result.
module acc_bank_stack #(
    parameter int W           = 8,
    parameter int IMM_W       = 4,
    parameter int NUM_ACC     = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clb,
    input  logic                       load_acc,
    input  logic [1:0]                 sel_src,
    input  logic [$clog2(NUM_ACC)-1:0] acc_sel,
    input  logic                       imm_signed,
    input  logic [IMM_W-1:0]           immediate,
    input  logic [W-1:0]               data_in,
    input  logic [W-1:0]               alu_out,
    input  logic                       push,
    input  logic                       pop,
    output logic [W-1:0]               acc_out,
    output logic                       flag_z,
    output logic                       flag_c,
    output logic                       flag_v,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [W-1:0]     bank  [NUM_ACC];
    logic [W-1:0]     stack [STACK_DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_dec;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic [W-1:0]     cur;
    logic [W-1:0]     imm_ext;
    logic [W:0]       sum;
    logic             add_v;
    logic [W-1:0]     add_res;
    logic [W-1:0]     src;
    logic [W-1:0]     wr_val;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             do_load;
    logic             err_set;

    assign cur     = bank[acc_sel];
    assign acc_out = cur;

    always_comb begin
        imm_ext = '0;
        imm_ext[IMM_W-1:0] = immediate;
        for (int i = IMM_W; i < W; i++) begin
            imm_ext[i] = imm_signed & immediate[IMM_W-1];
        end
    end

    assign sum   = {1'b0, cur} + {1'b0, data_in};
    assign add_v = (cur[W-1] == data_in[W-1]) && (sum[W-1] != cur[W-1]);

`ifdef ACC_SATURATE_EN
    // Overflow direction follows the shared operand sign.
    always_comb begin
        add_res = sum[W-1:0];
        if (add_v) begin
            add_res = cur[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign add_res = sum[W-1:0];
`endif

    always_comb begin
        case (sel_src)
            2'b00:   src = imm_ext;
            2'b01:   src = data_in;
            2'b10:   src = alu_out;
            default: src = add_res;
        endcase
    end

    assign full        = (sp == SP_W'(STACK_DEPTH));
    assign empty       = (sp == '0);
    assign stack_full  = full;
    assign stack_empty = empty;
    assign sp_dec      = sp - SP_W'(1);
    assign push_idx    = sp[IDX_W-1:0];
    assign top_idx     = sp_dec[IDX_W-1:0];

    // A push+pop conflict cancels both; a load proceeds unless a pop actually succeeds.
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign do_load = load_acc & ~do_pop;
    assign err_set = (push & pop) | (push & full) | (pop & empty);
    assign wr_val  = do_pop ? stack[top_idx] : src;

    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                bank[i] <= '0;
            end
            sp        <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            if (do_pop || do_load) begin
                bank[acc_sel] <= wr_val;
                flag_z        <= (wr_val == '0);
            end
            if (do_load && sel_src == 2'b11) begin
                flag_c <= sum[W];
                flag_v <= add_v;
            end
            if (do_push) begin
                sp <= sp + SP_W'(1);
            end else if (do_pop) begin
                sp <= sp_dec;
            end
            if (err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

    // Stack storage needs no reset; entries above sp are never read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack[push_idx] <= cur;
        end
    end

endmodule

// File: tb/tb_acc_bank_stack.sv
// Self-checking bench for acc_bank_stack: directed vector table, corner sequences,
// and randomized traffic against an arithmetic/queue reference model.
module tb_acc_bank_stack;

    logic       clk = 1'b0;
    logic       clb;
    logic       load_acc;
    logic [1:0] sel_src;
    logic [1:0] acc_sel;
    logic       imm_signed;
    logic [3:0] immediate;
    logic [7:0] data_in;
    logic [7:0] alu_out;
    logic       push;
    logic       pop;
    logic [7:0] acc_out;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    int checks = 0;
    int errors = 0;

    int mbank [4];
    int mstack [$];
    int mz, mc, mv, merr;

    typedef struct {
        int ld, sr, sel, sgn, imm, din, alu, psh, pp;
        int e_acc, e_z, e_c, e_v, e_full, e_empty, e_err;
    } vec_t;

`ifdef ACC_SATURATE_EN
    localparam int EXP_7F_PLUS_1 = 'h7F;
`else
    localparam int EXP_7F_PLUS_1 = 'h80;
`endif

    always #5 clk = ~clk;

    acc_bank_stack dut (
        .clk        (clk),
        .clb        (clb),
        .load_acc   (load_acc),
        .sel_src    (sel_src),
        .acc_sel    (acc_sel),
        .imm_signed (imm_signed),
        .immediate  (immediate),
        .data_in    (data_in),
        .alu_out    (alu_out),
        .push       (push),
        .pop        (pop),
        .acc_out    (acc_out),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_v     (flag_v),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        foreach (mbank[i]) mbank[i] = 0;
        mstack.delete();
        mz = 0; mc = 0; mv = 0; merr = 0;
    endtask

    // Reference behaviour written directly from the arithmetic rules.
    task automatic modelStep(input int ld, sr, sel, sgn, imm, din, alu, psh, pp);
        int src_v, s, sa, sd, st, popv;
        bit pop_ok, ovf;
        pop_ok = 0; ovf = 0; s = 0; popv = 0;
        if (psh && pp) merr = 1;
        else if (psh) begin
            if (mstack.size() == 4) merr = 1;
            else mstack.push_back(mbank[sel]);
        end else if (pp) begin
            if (mstack.size() == 0) merr = 1;
            else begin
                popv = mstack.pop_back();
                pop_ok = 1;
            end
        end
        case (sr)
            0: src_v = (sgn != 0 && imm >= 8) ? imm + 240 : imm;
            1: src_v = din;
            2: src_v = alu;
            default: begin
                s  = mbank[sel] + din;
                sa = (mbank[sel] >= 128) ? mbank[sel] - 256 : mbank[sel];
                sd = (din >= 128) ? din - 256 : din;
                st = sa + sd;
                ovf = (st > 127) || (st < -128);
                src_v = s % 256;
`ifdef ACC_SATURATE_EN
                if (st > 127) src_v = 127;
                else if (st < -128) src_v = 128;
`endif
            end
        endcase
        if (pop_ok) begin
            mbank[sel] = popv;
            mz = (popv == 0);
        end else if (ld != 0) begin
            mbank[sel] = src_v;
            mz = (src_v == 0);
            if (sr == 3) begin
                mc = (s > 255);
                mv = ovf;
            end
        end
    endtask

    task automatic applyStimulus(input int ld, sr, sel, sgn, imm, din, alu, psh, pp);
        load_acc   = ld[0];
        sel_src    = sr[1:0];
        acc_sel    = sel[1:0];
        imm_signed = sgn[0];
        immediate  = imm[3:0];
        data_in    = din[7:0];
        alu_out    = alu[7:0];
        push       = psh[0];
        pop        = pp[0];
        modelStep(ld, sr, sel, sgn, imm, din, alu, psh, pp);
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        load_acc = 0; sel_src = 0; acc_sel = 0; imm_signed = 0;
        immediate = 0; data_in = 0; alu_out = 0; push = 0; pop = 0;
    endtask

    task automatic resetPulse();
        idleInputs();
        clb = 1'b0;
        #3;
        clb = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " acc_out"}, int'(acc_out), mbank[acc_sel]);
        checkOutput({tag, " flag_z"}, int'(flag_z), mz);
        checkOutput({tag, " flag_c"}, int'(flag_c), mc);
        checkOutput({tag, " flag_v"}, int'(flag_v), mv);
        checkOutput({tag, " full"}, int'(stack_full), int'(mstack.size() == 4));
        checkOutput({tag, " empty"}, int'(stack_empty), int'(mstack.size() == 0));
        checkOutput({tag, " err"}, int'(stack_err), merr);
    endtask

    function automatic vec_t mk(int ld, sr, sel, sgn, imm, din, alu, psh, pp,
                                int ea, ez, ec, ev, ef, ee, er);
        vec_t v;
        v.ld = ld; v.sr = sr; v.sel = sel; v.sgn = sgn; v.imm = imm;
        v.din = din; v.alu = alu; v.psh = psh; v.pp = pp;
        v.e_acc = ea; v.e_z = ez; v.e_c = ec; v.e_v = ev;
        v.e_full = ef; v.e_empty = ee; v.e_err = er;
        return v;
    endfunction

    initial begin
        vec_t tbl [26];
        int dsel;

        tbl[0]  = mk(1,0,1,0,'hA,0,0,0,0,     'h0A,0,0,0,0,1,0);
        tbl[1]  = mk(1,0,1,1,'hA,0,0,0,0,     'hFA,0,0,0,0,1,0);
        tbl[2]  = mk(1,1,2,0,0,'h7F,0,0,0,    'h7F,0,0,0,0,1,0);
        tbl[3]  = mk(1,3,2,0,0,'h01,0,0,0,    EXP_7F_PLUS_1,0,0,1,0,1,0);
        tbl[4]  = mk(1,1,2,0,0,'hFF,0,0,0,    'hFF,0,0,1,0,1,0);
        tbl[5]  = mk(1,3,2,0,0,'h01,0,0,0,    'h00,1,1,0,0,1,0);
        tbl[6]  = mk(1,2,3,0,0,0,'h44,0,0,    'h44,0,1,0,0,1,0);
        tbl[7]  = mk(1,1,0,0,0,'h11,0,0,0,    'h11,0,1,0,0,1,0);
        tbl[8]  = mk(1,1,1,0,0,'h22,0,0,0,    'h22,0,1,0,0,1,0);
        tbl[9]  = mk(1,1,2,0,0,'h33,0,0,0,    'h33,0,1,0,0,1,0);
        tbl[10] = mk(0,0,0,0,0,0,0,1,0,       'h11,0,1,0,0,0,0);
        tbl[11] = mk(0,0,1,0,0,0,0,1,0,       'h22,0,1,0,0,0,0);
        tbl[12] = mk(0,0,2,0,0,0,0,1,0,       'h33,0,1,0,0,0,0);
        tbl[13] = mk(0,0,3,0,0,0,0,1,0,       'h44,0,1,0,1,0,0);
        tbl[14] = mk(0,0,0,0,0,0,0,1,0,       'h11,0,1,0,1,0,1);
        tbl[15] = mk(0,0,0,0,0,0,0,0,1,       'h44,0,1,0,0,0,1);
        tbl[16] = mk(0,0,0,0,0,0,0,0,1,       'h33,0,1,0,0,0,1);
        tbl[17] = mk(0,0,0,0,0,0,0,0,1,       'h22,0,1,0,0,0,1);
        tbl[18] = mk(0,0,0,0,0,0,0,0,1,       'h11,0,1,0,0,1,1);
        tbl[19] = mk(0,0,0,0,0,0,0,0,1,       'h11,0,1,0,0,1,1);
        tbl[20] = mk(1,1,0,0,0,'h10,0,0,0,    'h10,0,1,0,0,1,1);
        tbl[21] = mk(1,1,0,0,0,'h99,0,1,0,    'h99,0,1,0,0,0,1);
        tbl[22] = mk(0,0,0,0,0,0,0,0,1,       'h10,0,1,0,0,1,1);
        tbl[23] = mk(0,0,0,0,0,0,0,1,0,       'h10,0,1,0,0,0,1);
        tbl[24] = mk(1,1,0,0,0,'h55,0,0,1,    'h10,0,1,0,0,1,1);
        tbl[25] = mk(1,1,0,0,0,'h66,0,0,1,    'h66,0,1,0,0,1,1);

        idleInputs();
        clb = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        clb = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset with state present and no clock edge in between.
        applyStimulus(1,1,0,0,0,'h5A,0,0,0);
        checkOutput("pre-reset bank0", int'(acc_out), 'h5A);
        applyStimulus(1,3,0,0,0,'hB0,0,0,0);
        checkOutput("pre-reset carry", int'(flag_c), 1);
        clb = 1'b0;
        #2;
        checkOutput("async reset acc_out", int'(acc_out), 0);
        checkOutput("async reset empty", int'(stack_empty), 1);
        checkOutput("async reset full", int'(stack_full), 0);
        checkOutput("async reset flag_z", int'(flag_z), 0);
        checkOutput("async reset flag_c", int'(flag_c), 0);
        checkOutput("async reset err", int'(stack_err), 0);
        idleInputs();
        @(negedge clk);
        clb = 1'b1;
        modelReset();
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            applyStimulus(tbl[i].ld, tbl[i].sr, tbl[i].sel, tbl[i].sgn, tbl[i].imm,
                          tbl[i].din, tbl[i].alu, tbl[i].psh, tbl[i].pp);
            checkOutput($sformatf("vec%0d acc_out", i), int'(acc_out), tbl[i].e_acc);
            checkOutput($sformatf("vec%0d flag_z", i), int'(flag_z), tbl[i].e_z);
            checkOutput($sformatf("vec%0d flag_c", i), int'(flag_c), tbl[i].e_c);
            checkOutput($sformatf("vec%0d flag_v", i), int'(flag_v), tbl[i].e_v);
            checkOutput($sformatf("vec%0d full", i), int'(stack_full), tbl[i].e_full);
            checkOutput($sformatf("vec%0d empty", i), int'(stack_empty), tbl[i].e_empty);
            checkOutput($sformatf("vec%0d err", i), int'(stack_err), tbl[i].e_err);
        end

        // push+pop conflict from a clean error state, then reset with entries stacked.
        resetPulse();
        applyStimulus(1,1,0,0,0,'h77,0,0,0);
        applyStimulus(0,0,0,0,0,0,0,1,0);
        applyStimulus(0,0,0,0,0,0,0,1,0);
        applyStimulus(0,0,0,0,0,0,0,1,1);
        checkOutput("conflict err", int'(stack_err), 1);
        checkOutput("conflict empty", int'(stack_empty), 0);
        checkOutput("conflict full", int'(stack_full), 0);
        applyStimulus(1,1,1,0,0,'h21,0,0,0);
        applyStimulus(0,0,1,0,0,0,0,0,1);
        checkOutput("conflict kept sp pop", int'(acc_out), 'h77);
        checkOutput("conflict kept sp empty", int'(stack_empty), 0);
        applyStimulus(1,1,2,0,0,'hC3,0,0,0);
        applyStimulus(0,0,2,0,0,0,0,1,0);
        clb = 1'b0;
        #2;
        checkOutput("midstack reset empty", int'(stack_empty), 1);
        checkOutput("midstack reset err", int'(stack_err), 0);
        for (int b = 0; b < 4; b++) begin
            acc_sel = b[1:0];
            #1;
            checkOutput($sformatf("midstack reset bank%0d", b), int'(acc_out), 0);
        end
        idleInputs();
        @(negedge clk);
        clb = 1'b1;
        modelReset();
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            int pick;
            if (n % 80 == 79) resetPulse();
            pick = $urandom_range(0, 5);
            case (pick)
                0: dsel = 'h7F;
                1: dsel = 'h80;
                2: dsel = 'hFF;
                3: dsel = 'h01;
                default: dsel = $urandom_range(0, 255);
            endcase
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 1), $urandom_range(0, 15), dsel,
                          $urandom_range(0, 255), int'($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 3) == 0));
            checkModel($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
